// File: rtl/uart_arb_pkg.sv
// Shared types for the two-requester UART transmit arbiter.
// Pure declarations: no logic, no latency, no backpressure.
package uart_arb_pkg;
    localparam int NUM_REQ = 2;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2,
        HOLD     = 2'd3
    } arb_state_t;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte stream plus UART transmitter handshake; timeout_err exists only
// when UART_TX_ARB_TIMEOUT_EN is defined. Requesters/transmitter use master, arbiter uses slave.
interface uart_tx_arbiter_if;
    import uart_arb_pkg::*;

    logic  [NUM_REQ-1:0] req_valid;
    byte_t [NUM_REQ-1:0] req_data;
    logic  [NUM_REQ-1:0] req_last;
    logic  [NUM_REQ-1:0] req_ready;
    logic                tx_start;
    byte_t               tx_data;
    logic                tx_ack;
    logic  [NUM_REQ-1:0] grant;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic                timeout_err;

    modport master (output req_valid, req_data, req_last, tx_ack,
                    input  req_ready, tx_start, tx_data, grant, timeout_err);
    modport slave  (input  req_valid, req_data, req_last, tx_ack,
                    output req_ready, tx_start, tx_data, grant, timeout_err);
`else
    modport master (output req_valid, req_data, req_last, tx_ack,
                    input  req_ready, tx_start, tx_data, grant);
    modport slave  (input  req_valid, req_data, req_last, tx_ack,
                    output req_ready, tx_start, tx_data, grant);
`endif
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: ptr names the favoured requester, result is one-hot or zero.
// Combinational, zero latency; no backpressure of its own.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (ptr) begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
        end else begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin of two byte streams onto one UART transmitter; grant 1 cycle after
// valid, tx_start 2 cycles after; one byte in flight, waits on tx_ack (bounded by UART_TX_ARB_TIMEOUT_EN).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);
    arb_state_t          state, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d, win;
    logic                ptr, ptr_d;
    logic                gidx;
    logic                last_q;
    logic                start_q;
    byte_t               data_q;
    logic                to_fire;

    assign gidx = grant_q[1];

    rr_arbiter_2 u_rr (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (win)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] to_cnt;
    logic          to_q;

    // An ack arriving on the limit cycle still completes the byte normally.
    assign to_fire = (state == WAIT_ACK || state == HOLD)
                   && (to_cnt == CW'(TIMEOUT_CYCLES - 1))
                   && !(state == WAIT_ACK && bus.tx_ack);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            to_q   <= 1'b0;
        end else begin
            to_q <= to_fire;
            if (state_d != state || !(state == WAIT_ACK || state == HOLD))
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    assign bus.timeout_err = to_q;
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        state_d = state;
        grant_d = grant_q;
        ptr_d   = ptr;
        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_d = SEND;
                    grant_d = win;
                end
            end
            SEND: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (bus.tx_ack) begin
                    if (last_q) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = ~gidx;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Only the owner may continue; the other side waits for packet end.
                if (bus.req_valid[gidx]) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
        if (to_fire) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = ~gidx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state   <= state_d;
            grant_q <= grant_d;
            ptr     <= ptr_d;
            start_q <= (state == SEND);
            if (state == SEND) begin
                data_q <= bus.req_data[gidx];
                last_q <= bus.req_last[gidx];
            end
        end
    end

    assign bus.req_ready = (state == SEND) ? grant_q : '0;
    assign bus.tx_start  = start_q;
    assign bus.tx_data   = data_q;
    assign bus.grant     = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written corner sequences and a
// randomized packet run scored against a packet-level round-robin model.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if u_if ();

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [1:0] v;
        byte_t      d0;
        logic [1:0] l;
        logic       ack;
        logic [1:0] g;
        logic [1:0] rdy;
        logic       st;
        byte_t      dat;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       r;
    } ent_t;

    ent_t rq0[$], rq1[$], expq[$];

    task automatic do_reset();
        rst = 1'b0;
        u_if.tx_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start(input string name);
        for (int k = 0; k < 50 && !u_if.tx_start; k++) @(negedge clk);
        check({name, ".start"}, u_if.tx_start, 1);
    endtask

    task automatic ack_now();
        u_if.tx_ack = 1'b1;
        @(negedge clk);
        u_if.tx_ack = 1'b0;
    endtask

    task automatic build_pkts(input int npk, input int maxlen);
        rq0.delete();
        rq1.delete();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < npk; p++) begin
                int   len;
                ent_t e;
                len = $urandom_range(1, maxlen);
                for (int b = 0; b < len; b++) begin
                    e.d = 8'($urandom);
                    e.l = (b == len - 1);
                    e.r = r[0];
                    if (r == 0) rq0.push_back(e);
                    else        rq1.push_back(e);
                end
            end
        end
    endtask

    // Whole packets in order; the favoured side alternates after every packet.
    task automatic model();
        ent_t a0[$], a1[$];
        ent_t e;
        int   fav, pick;
        a0 = rq0;
        a1 = rq1;
        fav = 0;
        expq.delete();
        while (a0.size() > 0 || a1.size() > 0) begin
            if (fav == 0) pick = (a0.size() > 0) ? 0 : 1;
            else          pick = (a1.size() > 0) ? 1 : 0;
            do begin
                if (pick == 0) e = a0.pop_front();
                else           e = a1.pop_front();
                expq.push_back(e);
            end while (!e.l);
            fav = 1 - pick;
        end
    endtask

    task automatic run_engine(input string tag, input bit bubbles);
        ent_t  c0[$], c1[$];
        ent_t  f;
        bit    acc[2];
        int    bub[2];
        bit    busy;
        int    wait_n, got, cyc, sz;
        byte_t cur;
        c0 = rq0;
        c1 = rq1;
        model();
        u_if.req_valid = '0;
        u_if.req_last  = '0;
        do_reset();
        acc = '{0, 0};
        bub = '{0, 0};
        busy = 0; wait_n = 0; got = 0; cyc = 0; cur = '0;
        while ((got < expq.size() || busy) && cyc < 4000) begin
            u_if.tx_ack = 1'b0;
            if (u_if.tx_start) begin
                if (got < expq.size()) begin
                    check({tag, ".data"}, u_if.tx_data, expq[got].d);
                    check({tag, ".grant"}, u_if.grant, expq[got].r ? 2'b10 : 2'b01);
                end else begin
                    check({tag, ".extra_start"}, u_if.tx_start, 0);
                end
                got++;
                cur = u_if.tx_data;
                busy = 1;
                wait_n = $urandom_range(0, 3);
            end else if (busy) begin
                check({tag, ".hold"}, u_if.tx_data, cur);
            end
            if (busy) begin
                if (wait_n == 0) begin
                    u_if.tx_ack = 1'b1;
                    busy = 0;
                end else begin
                    wait_n--;
                end
            end
            for (int i = 0; i < 2; i++) begin
                sz = (i == 0) ? c0.size() : c1.size();
                if (acc[i]) begin
                    if (i == 0) f = c0.pop_front();
                    else        f = c1.pop_front();
                    acc[i] = 0;
                    sz--;
                    if (bubbles && !f.l) bub[i] = $urandom_range(0, 2);
                end
                if (bub[i] > 0) begin
                    u_if.req_valid[i] = 1'b0;
                    bub[i]--;
                end else if (sz > 0) begin
                    f = (i == 0) ? c0[0] : c1[0];
                    u_if.req_valid[i] = 1'b1;
                    u_if.req_data[i]  = f.d;
                    u_if.req_last[i]  = f.l;
                end else begin
                    u_if.req_valid[i] = 1'b0;
                end
                if (u_if.req_ready[i]) acc[i] = 1;
            end
            @(negedge clk);
            cyc++;
        end
        u_if.tx_ack = 1'b0;
        u_if.req_valid = '0;
        check({tag, ".count"}, got, expq.size());
        check({tag, ".idle_grant"}, u_if.grant, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t  vt[10];
        byte_t bv[3];

        u_if.req_valid = '0;
        u_if.req_data  = '0;
        u_if.req_last  = '0;
        u_if.tx_ack    = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst.grant",     u_if.grant,     2'b00);
        check("rst.tx_start",  u_if.tx_start,  0);
        check("rst.tx_data",   u_if.tx_data,   8'h00);
        check("rst.req_ready", u_if.req_ready, 2'b00);
`ifdef UART_TX_ARB_TIMEOUT_EN
        check("rst.timeout_err", u_if.timeout_err, 0);
`endif

        // Both requesters busy from reset: four single-byte packets must alternate 0,1,0,1.
        build_pkts(2, 1);
        run_engine("alt", 0);

        // Single byte A5, ack five cycles after tx_start, then stray acks while idle.
        vt[0] = '{2'b01, 8'hA5, 2'b01, 1'b0, 2'b01, 2'b01, 1'b0, 8'h00};
        vt[1] = '{2'b00, 8'hA5, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 8'hA5};
        vt[2] = '{2'b00, 8'hA5, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 8'hA5};
        vt[3] = '{2'b00, 8'hA5, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 8'hA5};
        vt[4] = '{2'b00, 8'hA5, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 8'hA5};
        vt[5] = '{2'b00, 8'hA5, 2'b01, 1'b0, 2'b01, 2'b00, 1'b0, 8'hA5};
        vt[6] = '{2'b00, 8'hA5, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 8'hA5};
        vt[7] = '{2'b00, 8'hA5, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 8'hA5};
        vt[8] = '{2'b00, 8'hA5, 2'b01, 1'b1, 2'b00, 2'b00, 1'b0, 8'hA5};
        vt[9] = '{2'b00, 8'hA5, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 8'hA5};
        u_if.req_valid = '0;
        do_reset();
        u_if.req_data[1] = 8'h00;
        for (int i = 0; i < 10; i++) begin
            u_if.req_valid   = vt[i].v;
            u_if.req_data[0] = vt[i].d0;
            u_if.req_last    = vt[i].l;
            u_if.tx_ack      = vt[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d.grant", i),     u_if.grant,     vt[i].g);
            check($sformatf("vec%0d.req_ready", i), u_if.req_ready, vt[i].rdy);
            check($sformatf("vec%0d.tx_start", i),  u_if.tx_start,  vt[i].st);
            check($sformatf("vec%0d.tx_data", i),   u_if.tx_data,   vt[i].dat);
        end
        u_if.tx_ack = 1'b0;

        // Three-byte packet on req1 while req0 waits; req1 is favoured after req0's packet.
        bv[0] = 8'h11; bv[1] = 8'h22; bv[2] = 8'h33;
        u_if.req_valid   = 2'b11;
        u_if.req_data[0] = 8'h77;
        u_if.req_last    = 2'b01;
        for (int b = 0; b < 3; b++) begin
            u_if.req_data[1] = bv[b];
            u_if.req_last[1] = (b == 2);
            wait_start($sformatf("pkt.b%0d", b));
            check($sformatf("pkt.b%0d.data", b),  u_if.tx_data, bv[b]);
            check($sformatf("pkt.b%0d.grant", b), u_if.grant,   2'b10);
            if (b != 1) u_if.req_valid[1] = 1'b0;
            @(negedge clk);
            check($sformatf("pkt.b%0d.one_pulse", b), u_if.tx_start, 0);
            @(negedge clk);
            check($sformatf("pkt.b%0d.data_hold", b), u_if.tx_data, bv[b]);
            ack_now();
            if (b == 0) begin
                for (int k = 0; k < 3; k++) begin
                    u_if.tx_ack = (k == 1);
                    @(negedge clk);
                    check($sformatf("hold%0d.grant", k),     u_if.grant,     2'b10);
                    check($sformatf("hold%0d.tx_start", k),  u_if.tx_start,  0);
                    check($sformatf("hold%0d.req_ready", k), u_if.req_ready, 2'b00);
                end
                u_if.tx_ack = 1'b0;
                u_if.req_valid[1] = 1'b1;
            end
            check($sformatf("pkt.b%0d.after_ack", b), u_if.grant, (b < 2) ? 2'b10 : 2'b00);
        end
        @(negedge clk);
        check("pkt.req0_next", u_if.grant, 2'b01);
        wait_start("pkt.req0");
        check("pkt.req0.data", u_if.tx_data, 8'h77);
        u_if.req_valid = '0;
        ack_now();
        check("pkt.req0.done", u_if.grant, 2'b00);

        // Reset asserted on the tx_start cycle.
        u_if.req_valid   = 2'b01;
        u_if.req_data[0] = 8'h5A;
        u_if.req_last    = 2'b01;
        wait_start("rst_mid");
        #1 rst = 1'b0;
        #1;
        check("rst_mid.grant",     u_if.grant,     2'b00);
        check("rst_mid.tx_start",  u_if.tx_start,  0);
        check("rst_mid.tx_data",   u_if.tx_data,   8'h00);
        check("rst_mid.req_ready", u_if.req_ready, 2'b00);
        u_if.req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rst_quiet%0d", k), {u_if.tx_start, u_if.grant}, 3'b000);
        end
        u_if.req_valid   = 2'b10;
        u_if.req_data[1] = 8'h3C;
        u_if.req_last    = 2'b10;
        @(negedge clk);
        check("rst_new.grant", u_if.grant, 2'b10);
        wait_start("rst_new");
        check("rst_new.data", u_if.tx_data, 8'h3C);
        u_if.req_valid = '0;
        ack_now();

`ifdef UART_TX_ARB_TIMEOUT_EN
        u_if.req_valid = '0;
        do_reset();
        u_if.req_valid   = 2'b11;
        u_if.req_data[0] = 8'hC1;
        u_if.req_data[1] = 8'hC2;
        u_if.req_last    = 2'b11;
        wait_start("to0");
        check("to0.grant", u_if.grant, 2'b01);
        check("to0.data",  u_if.tx_data, 8'hC1);
        u_if.req_valid[0] = 1'b0;
        for (int j = 1; j < TO; j++) begin
            @(negedge clk);
            check($sformatf("to.wait%0d", j), {u_if.timeout_err, u_if.grant}, 3'b001);
        end
        @(negedge clk);
        check("to.pulse", {u_if.timeout_err, u_if.grant}, 3'b100);
        @(negedge clk);
        check("to.next", {u_if.timeout_err, u_if.grant}, 3'b010);
        wait_start("to1");
        check("to1.data", u_if.tx_data, 8'hC2);
        u_if.req_valid = '0;
        ack_now();
        check("to1.done", u_if.grant, 2'b00);
`endif

        // Random packet mix with intra-packet bubbles and random ack delays.
        build_pkts(6, 4);
        run_engine("rnd", 1);
        build_pkts(5, 3);
        run_engine("rnd2", 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 4096, meaning the acknowledge-wait limit in clk cycles (used only under UART_TX_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have the port clk  input  1  system clock; all logic on rising edge; one clock.
REQ-003 The block SHALL have the port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have the port req_valid  input  2  byte-valid per requester (index 0 = status, 1 = grid dump).
REQ-005 The block SHALL have the port req_data  input  2x8  byte per requester.
REQ-006 The block SHALL have the port req_last  input  2  final byte of packet, qualified by req_valid.
REQ-007 The block SHALL have the port req_ready  output  2  byte accepted this cycle.
REQ-008 The block SHALL have the port tx_start  output  1  one-cycle pulse to the UART transmitter.
REQ-009 The block SHALL have the port tx_data  output  8  byte to the transmitter, stable from tx_start until tx_ack.
REQ-010 The block SHALL have the port tx_ack  input  1  one-cycle done pulse from the transmitter, already synchronized to clk.
REQ-011 The block SHALL have the port grant  output  2  one-hot current owner; 0 when idle.
REQ-012 The block SHALL have the port timeout_err  output  1  one-cycle timeout pulse; present only under UART_TX_ARB_TIMEOUT_EN.

Function
REQ-013 The FSM SHALL have the states IDLE, SEND, WAIT_ACK and HOLD.
REQ-014 In IDLE with any req_valid set at cycle N, grant SHALL go one-hot at N+1 and state SHALL go to SEND.
REQ-015 Arbitration SHALL be round-robin: with both valid, the requester selected by the priority pointer wins.
REQ-016 The priority pointer SHALL move to the other requester only when a packet completes or times out.
REQ-017 In SEND, req_ready[granted] SHALL be 1 (combinational from state and grant) for exactly one cycle; tx_data SHALL capture req_data[granted] and the captured last flag SHALL be stored; the next state SHALL be WAIT_ACK.
REQ-018 tx_start SHALL be high for exactly the first WAIT_ACK cycle; tx_data SHALL hold until tx_ack.
REQ-019 tx_ack SHALL be honoured only in WAIT_ACK, including the tx_start cycle; tx_ack in any other state SHALL be ignored.
REQ-020 On tx_ack with the stored last flag = 1: grant SHALL go to 0, the pointer SHALL advance, and the state SHALL go to IDLE.
REQ-021 On tx_ack with the stored last flag = 0: the state SHALL go to HOLD and grant SHALL be kept.
REQ-022 In HOLD, req_valid[granted] = 1 SHALL move the state to SEND; the other requester SHALL never preempt mid-packet.
REQ-023 req_ready SHALL never be high in IDLE, WAIT_ACK or HOLD.
REQ-024 A packet SHALL have no length limit.

Reset
REQ-025 On rst low, asynchronously: state = IDLE, grant = 0, pointer = requester 0, tx_start = 0, tx_data = 8'h00, req_ready = 0, timeout_err = 0, timeout counter = 0.
REQ-026 Reset mid-packet SHALL abandon the packet with no further tx_start.

Configuration
REQ-027 Macro UART_TX_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT_ACK and HOLD and clear on every state change.
REQ-028 When that counter reaches TIMEOUT_CYCLES-1, the next cycle SHALL pulse timeout_err, clear grant, advance the pointer and enter IDLE.
REQ-029 Macro undefined: the timeout_err port and counter SHALL be absent and the block SHALL wait indefinitely.

Structure
REQ-030 Package uart_arb_pkg SHALL hold NUM_REQ = 2, typedef byte_t (8 bits) and the enum arb_state_t {IDLE, SEND, WAIT_ACK, HOLD}.
REQ-031 Sub-module rr_arbiter_2 SHALL take request vector and pointer and return a one-hot winner, combinational only; the pointer register SHALL live in uart_tx_arbiter.

Verification
REQ-032 The bench SHALL drive req0 single byte 8'hA5, last = 1, then tx_ack 5 cycles after tx_start and require: grant = 01 at N+1, req_ready[0] at N+1, tx_start at N+2, tx_data = A5, grant = 00 after ack.
REQ-033 The bench SHALL drive both requesters valid from reset and require req0 to win first and req1 to win the next packet, with alternation over 4 packets.
REQ-034 The bench SHALL drive a 3-byte packet on req1 (11,22,33, last on 33) while req0 is held valid and require 3 tx_start pulses in order with no grant change until after the third ack.
REQ-035 The bench SHALL pulse tx_ack in IDLE and in HOLD and require no state change and no tx_start.
REQ-036 The bench SHALL assert rst low during WAIT_ACK and require all outputs to reach reset values immediately and no tx_start after release until a new req_valid.
REQ-037 With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, the bench SHALL withhold tx_ack and require timeout_err for one cycle, grant = 00, and the other requester served next.
